// File: rtl/latent_output_reader.sv
// ---------------------------------------------------------------------------
// latent_output_reader
//
// Consumer of the latent-space dense layer's output BRAM read port. When
// the dense layer raises its done level, this block reads all NEURON latent
// values through the BRAM address/enable/data port. It waits out the BRAM
// read latency for each word and then offers the word to the decoder as a
// valid/ready stream with index and last flags. Each rising edge of src_done
// starts one pass.
//
// Optional build macro:
//   LATENT_RELU_EN - when defined, a negative captured word (MSB set) is
//                    replaced by zero on m_data. Timing does not change.
//
// Ports:
//   clk                  in   clock, rising edge
//   reset                in   asynchronous, active-high reset
//   src_done             in   dense-layer done level
//   dense_output_address out  BRAM read address
//   dense_output_enable  out  BRAM read enable
//   dense_output_data    in   BRAM read data (DW bits)
//   m_valid / m_ready    out/in stream handshake
//   m_data               out  latent value (DW bits, signed)
//   m_index              out  index of m_data
//   m_last               out  high with m_valid on element NEURON-1
//   busy                 out  pass in progress
//   done                 out  pass complete, sticky
// ---------------------------------------------------------------------------
module latent_output_reader #(
    parameter int NEURON         = 2,
    parameter int INTEGER_WIDTH  = 10,
    parameter int FRACTION_WIDTH = 10,
    parameter int ADDR_WIDTH     = 2,
    parameter int READ_LATENCY   = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    src_done,
    output logic [ADDR_WIDTH-1:0]                   dense_output_address,
    output logic                                    dense_output_enable,
    input  logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0] dense_output_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0]                   m_index,
    output logic                                    m_last,
    output logic                                    busy,
    output logic                                    done
);

    localparam int DW    = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0]      LAT_CNT   = CNT_W'(READ_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NEURON - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Word shaping applied at capture time (optional ReLU clamp).
    function automatic logic [DW-1:0] shape_word(input logic [DW-1:0] w);
`ifdef LATENT_RELU_EN
        if (w[DW-1]) begin
            shape_word = {DW{1'b0}};
        end else begin
            shape_word = w;
        end
`else
        shape_word = w;
`endif
    endfunction

    state_t                state_r,    state_s;
    logic                  src_done_q_r;
    logic [ADDR_WIDTH-1:0] addr_r,     addr_s;
    logic                  en_r,       en_s;
    logic                  busy_r,     busy_s;
    logic                  done_r,     done_s;
    logic [CNT_W-1:0]      wait_cnt_r, wait_cnt_s;
    logic                  m_valid_r,  m_valid_s;
    logic [DW-1:0]         m_data_r,   m_data_s;
    logic [ADDR_WIDTH-1:0] m_index_r,  m_index_s;
    logic                  m_last_r,   m_last_s;
    logic                  start_s;

    // Rising edge of the dense layer's done level.
    assign start_s = src_done & ~src_done_q_r;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        en_s       = en_r;
        busy_s     = busy_r;
        done_s     = done_r;
        wait_cnt_s = wait_cnt_r;
        m_valid_s  = m_valid_r;
        m_data_s   = m_data_r;
        m_index_s  = m_index_r;
        m_last_s   = m_last_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    addr_s     = {ADDR_WIDTH{1'b0}};
                    en_s       = 1'b1;
                    busy_s     = 1'b1;
                    done_s     = 1'b0;
                    wait_cnt_s = {CNT_W{1'b0}};
                    state_s    = ST_WAIT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT: begin
                // Address is held here, so the BRAM word at the end of the
                // wait belongs to addr_r.
                if (wait_cnt_r == LAT_CNT) begin
                    m_data_s  = shape_word(dense_output_data);
                    m_index_s = addr_r;
                    m_last_s  = (addr_r == LAST_ADDR);
                    m_valid_s = 1'b1;
                    state_s   = ST_VALID;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_W'(1);
                end
            end
            ST_VALID: begin
                if (m_ready) begin
                    m_valid_s = 1'b0;
                    if (m_last_r) begin
                        m_last_s = 1'b0;
                        en_s     = 1'b0;
                        busy_s   = 1'b0;
                        done_s   = 1'b1;
                        state_s  = ST_DONE;
                    end else begin
                        addr_s     = addr_r + ADDR_WIDTH'(1);
                        wait_cnt_s = {CNT_W{1'b0}};
                        state_s    = ST_WAIT;
                    end
                end else begin
                    m_valid_s = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a quiet idle.
                state_s   = ST_IDLE;
                en_s      = 1'b0;
                busy_s    = 1'b0;
                m_valid_s = 1'b0;
                m_last_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            src_done_q_r <= 1'b0;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            en_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            wait_cnt_r   <= {CNT_W{1'b0}};
            m_valid_r    <= 1'b0;
            m_data_r     <= {DW{1'b0}};
            m_index_r    <= {ADDR_WIDTH{1'b0}};
            m_last_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            src_done_q_r <= src_done;
            addr_r       <= addr_s;
            en_r         <= en_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            wait_cnt_r   <= wait_cnt_s;
            m_valid_r    <= m_valid_s;
            m_data_r     <= m_data_s;
            m_index_r    <= m_index_s;
            m_last_r     <= m_last_s;
        end
    end

    assign dense_output_address = addr_r;
    assign dense_output_enable  = en_r;
    assign m_valid              = m_valid_r;
    assign m_data               = m_data_r;
    assign m_index              = m_index_r;
    assign m_last               = m_last_r;
    assign busy                 = busy_r;
    assign done                 = done_r;

endmodule

// File: tb/tb_latent_output_reader.sv
// ---------------------------------------------------------------------------
// Testbench for latent_output_reader. Two instances: u1 with default
// parameters (NEURON=2, READ_LATENCY=1) and u3 with NEURON=4,
// READ_LATENCY=3, each fed by a BRAM model of matching latency.
// ---------------------------------------------------------------------------
module tb_latent_output_reader;

    localparam int DW = 20;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    idx;
        logic          last;
    } beat_t;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic [1:0]    idx;
        logic          last;
        logic          busy;
        logic          done;
        logic          en;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic          src_done1 = 1'b0, m_ready1 = 1'b1;
    logic [1:0]    addr1, idx1;
    logic          en1, valid1, last1, busy1, done1;
    logic [DW-1:0] dout1, data1;
    logic [DW-1:0] mem1 [0:3];
    logic [DW-1:0] pipe1;

    logic          src_done3 = 1'b0, m_ready3 = 1'b1;
    logic [1:0]    addr3, idx3;
    logic          en3, valid3, last3, busy3, done3;
    logic [DW-1:0] dout3, data3;
    logic [DW-1:0] mem3 [0:3];
    logic [DW-1:0] pipe3 [0:2];

    int n_checks = 0;
    int n_fail   = 0;
    beat_t q1[$];
    beat_t q3[$];

    always #5 clk = ~clk;

    latent_output_reader u1 (
        .clk(clk), .reset(reset), .src_done(src_done1),
        .dense_output_address(addr1), .dense_output_enable(en1),
        .dense_output_data(dout1), .m_valid(valid1), .m_ready(m_ready1),
        .m_data(data1), .m_index(idx1), .m_last(last1),
        .busy(busy1), .done(done1)
    );

    latent_output_reader #(.NEURON(4), .READ_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .src_done(src_done3),
        .dense_output_address(addr3), .dense_output_enable(en3),
        .dense_output_data(dout3), .m_valid(valid3), .m_ready(m_ready3),
        .m_data(data3), .m_index(idx3), .m_last(last3),
        .busy(busy3), .done(done3)
    );

    // BRAM models: address sampled when enabled, word appears after latency.
    always @(posedge clk) begin
        if (en1) pipe1 <= mem1[addr1];
        if (en3) pipe3[0] <= mem3[addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign dout1 = pipe1;
    assign dout3 = pipe3[2];

    // Reference view of a latent word as seen by the decoder.
    function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef LATENT_RELU_EN
        return ($signed(w) < 0) ? 20'd0 : w;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare a logged pass against the expected element sequence.
    task automatic check_pass(input string name, input beat_t q[$], input logic [DW-1:0] m [0:3], input int n);
        chk({name, " beat count"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk({name, " data"}, 32'(q[i].data), 32'(model_word(m[i])));
            chk({name, " index"}, 32'(q[i].idx), 32'(i));
            chk({name, " last"}, 32'(q[i].last), 32'(i == n - 1));
        end
    endtask

    // Handshake logger; inputs change only just after posedge, so the
    // negedge view is what the next posedge will sample.
    logic          hold3_r = 1'b0;
    logic [DW-1:0] held3_r;
    always @(negedge clk) begin
        if (!reset && valid1 && m_ready1) q1.push_back({data1, idx1, last1});
        if (!reset && valid3 && m_ready3) q3.push_back({data3, idx3, last3});
        if (!reset && hold3_r) begin
            chk("u3 hold valid", 32'(valid3), 32'd1);
            chk("u3 hold data", 32'(data3), 32'(held3_r));
        end
        hold3_r <= !reset && valid3 && !m_ready3;
        held3_r <= data3;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [7];
        int   spur;
        tbl[0] = '{1'b0, 20'h00000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1}; // edge 10
        tbl[1] = '{1'b0, 20'h00000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1}; // edge 11
        tbl[2] = '{1'b1, 20'h00400, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1}; // edge 12
        tbl[3] = '{1'b0, 20'h00000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1}; // edge 13
        tbl[4] = '{1'b0, 20'h00000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1}; // edge 14
        tbl[5] = '{1'b1, model_word(20'hFFC00), 2'd1, 1'b1, 1'b1, 1'b0, 1'b1}; // edge 15
        tbl[6] = '{1'b0, 20'h00000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}; // edge 16

        mem1[0] = 20'h00400; mem1[1] = 20'hFFC00; mem1[2] = 20'h12345; mem1[3] = 20'h54321;
        for (int i = 0; i < 4; i++) mem3[i] = 20'(i);

        // Reset state.
        step(); step();
        chk("reset u1 outputs", 32'({addr1, en1, valid1, data1, idx1, last1, busy1, done1}), 32'd0);
        chk("reset u3 outputs", 32'({addr3, en3, valid3, data3, idx3, last3, busy3, done3}), 32'd0);
        reset = 1'b0;

        // Basic pass: src_done sampled high at edge 10.
        for (int e = 1; e <= 9; e++) step();
        src_done1 = 1'b1;
        for (int e = 0; e < 7; e++) begin
            step();
            chk($sformatf("basic e%0d valid", e + 10), 32'(valid1), 32'(tbl[e].valid));
            chk($sformatf("basic e%0d busy", e + 10), 32'(busy1), 32'(tbl[e].busy));
            chk($sformatf("basic e%0d done", e + 10), 32'(done1), 32'(tbl[e].done));
            chk($sformatf("basic e%0d enable", e + 10), 32'(en1), 32'(tbl[e].en));
            if (tbl[e].valid) begin
                chk($sformatf("basic e%0d data", e + 10), 32'(data1), 32'(tbl[e].data));
                chk($sformatf("basic e%0d index", e + 10), 32'(idx1), 32'(tbl[e].idx));
                chk($sformatf("basic e%0d last", e + 10), 32'(last1), 32'(tbl[e].last));
            end
        end
        check_pass("basic", q1, mem1, 2);

        // src_done held high: no restart.
        spur = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (valid1 || busy1 || !done1) spur++;
        end
        chk("no restart activity", 32'(spur), 32'd0);
        chk("no restart beats", 32'(q1.size()), 32'd2);
        chk("no restart done", 32'(done1), 32'd1);

        // Low-then-high src_done starts a second pass.
        src_done1 = 1'b0; step();
        src_done1 = 1'b1; step();
        chk("restart done cleared", 32'(done1), 32'd0);
        chk("restart busy", 32'(busy1), 32'd1);
        for (int k = 0; k < 30 && !done1; k++) step();
        chk("restart done set", 32'(done1), 32'd1);
        chk("restart total beats", 32'(q1.size()), 32'd4);

        // Backpressure on the first element.
        q1.delete();
        m_ready1 = 1'b0;
        src_done1 = 1'b0; step();
        src_done1 = 1'b1;
        for (int k = 0; k < 10 && !valid1; k++) step();
        for (int k = 0; k < 5; k++) begin
            chk("bp valid held", 32'(valid1), 32'd1);
            chk("bp data held", 32'(data1), 32'h00400);
            step();
        end
        m_ready1 = 1'b1;
        for (int k = 0; k < 30 && !done1; k++) step();
        check_pass("backpressure", q1, mem1, 2);

        // Reset while waiting on element 1.
        q1.delete();
        src_done1 = 1'b0; step();
        src_done1 = 1'b1;
        for (int k = 0; k < 10 && !valid1; k++) step();
        step();
        chk("pre-reset in element 1 wait", 32'({valid1, addr1, busy1}), 32'({1'b0, 2'd1, 1'b1}));
        #1 reset = 1'b1;
        #1;
        chk("async reset outputs", 32'({addr1, en1, valid1, data1, idx1, last1, busy1, done1}), 32'd0);
        step(); step();
        q1.delete();
        reset = 1'b0;
        step();
        chk("post-reset start busy", 32'(busy1), 32'd1);
        for (int k = 0; k < 30 && !done1; k++) step();
        chk("post-reset done", 32'(done1), 32'd1);
        check_pass("post-reset", q1, mem1, 2);

        // READ_LATENCY=3: valid rises 4 edges after the start edge.
        q3.delete();
        mem3[0] = 20'h80001; mem3[1] = 20'h7FFFF; mem3[2] = 20'h00000; mem3[3] = 20'hFFFFF;
        m_ready3 = 1'b1;
        src_done3 = 1'b1; step();
        chk("rl3 start busy", 32'(busy3), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("rl3 valid low +%0d", k), 32'(valid3), 32'd0);
        end
        step();
        chk("rl3 valid +4", 32'(valid3), 32'd1);
        chk("rl3 first data", 32'(data3), 32'(model_word(mem3[0])));
        for (int k = 0; k < 100 && !done3; k++) step();
        check_pass("rl3 directed", q3, mem3, 4);

        // Randomized passes with random backpressure.
        for (int p = 0; p < 6; p++) begin
            q3.delete();
            for (int i = 0; i < 4; i++) mem3[i] = 20'($urandom);
            src_done3 = 1'b0; m_ready3 = 1'($urandom_range(0, 1)); step();
            src_done3 = 1'b1; step();
            for (int k = 0; k < 300 && !done3; k++) begin
                m_ready3 = 1'($urandom_range(0, 1));
                step();
            end
            chk("rand pass done", 32'(done3), 32'd1);
            check_pass($sformatf("rand pass %0d", p), q3, mem3, 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/latent_output_reader.md
Name: latent_output_reader

Overview:
- Consumer end of the latent-space dense layer's output BRAM read port.
- Waits for the dense layer's done flag, then reads all NEURON latent values through the layer's address/enable/data port, honouring BRAM read latency.
- Presents each value to the decoder stage as a valid/ready stream with index and last flags.
- Frees the decoder from BRAM timing; one pass runs per rising edge of the dense layer's done flag.

Parameters:
- NEURON, 2, number of latent values read per pass (must be at least 1).
- INTEGER_WIDTH, 10, integer bits of signed fixed-point data.
- FRACTION_WIDTH, 10, fraction bits; data width is DW = INTEGER_WIDTH+FRACTION_WIDTH.
- ADDR_WIDTH, 2, width of the BRAM read address.
- READ_LATENCY, 1, number of clk edges from the BRAM sampling an address to douta being valid (must be at least 1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- src_done  in  1  done level from the dense layer; held high once that layer finishes.
- dense_output_address  out  ADDR_WIDTH  BRAM read address.
- dense_output_enable  out  1  BRAM read enable.
- dense_output_data  in  DW  BRAM read data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream ready.
- m_data  out  DW  signed latent value.
- m_index  out  ADDR_WIDTH  index of the current m_data.
- m_last  out  1  high with m_valid on element NEURON-1.
- busy  out  1  pass in progress.
- done  out  1  pass complete; sticky.

Behaviour:
- Reset values: all outputs 0, state IDLE, src_done_q 0.
- src_done_q is a one-cycle registered copy of src_done. A start is src_done && !src_done_q.
- IDLE:
  - On start: dense_output_address<=0, dense_output_enable<=1, busy<=1, done<=0, wait_cnt<=0, go to WAIT.
- WAIT:
  - wait_cnt increments each cycle.
  - When wait_cnt==READ_LATENCY: capture dense_output_data into m_data, set m_index<=address, m_last<=(address==NEURON-1), m_valid<=1, go to VALID.
  - Net timing: m_valid rises READ_LATENCY+1 edges after the start-detect edge (2 edges at default).
  - Address stays stable throughout WAIT.
- VALID:
  - m_valid, m_data, m_index and m_last are held stable until an edge where m_ready=1.
  - On handshake, if not last: m_valid<=0, address+1, wait_cnt<=0, go to WAIT.
  - On handshake, if last: m_valid<=0, m_last<=0, dense_output_enable<=0, busy<=0, done<=1, go to DONE.
- Throughput with m_ready tied high: one element per READ_LATENCY+2 cycles. m_valid drops for at least one cycle between elements.
- m_valid never depends combinationally on m_ready.
- DONE:
  - done stays held.
  - A new start (src_done low then high) re-enters the pass exactly as in IDLE and clears done.
  - src_done held high after the pass causes no restart.
- src_done falling mid-pass is ignored; the pass completes.
- A start seen while busy is ignored.
- Reset asserted mid-pass aborts immediately: all outputs 0, state IDLE.
  - After reset release, a src_done that is already high counts as a start on the first edge, because src_done_q resets to 0.
- m_data is a raw copy of the BRAM word, apart from the optional feature below. No arithmetic, no width change.
- m_index wraps naturally; NEURON must be at most 2^ADDR_WIDTH.

Optional Feature:
- Macro LATENT_RELU_EN.
- When defined: at capture, a word whose MSB is 1 (negative) is replaced by 0 on m_data. Non-negative words pass unchanged. Timing is identical.
- When undefined: m_data is always the raw signed BRAM word.

Test Plan:
- Basic pass:
  - Setup: NEURON=2, READ_LATENCY=1, BRAM[0]=0x00400 (+1.0), BRAM[1]=0xFFC00 (-1.0), m_ready=1, src_done rises at edge 10.
  - Response: m_valid high at edge 12 with m_data=0x00400, m_index=0, m_last=0.
  - Then m_valid high at edge 15 with m_data=0xFFC00, m_index=1, m_last=1.
  - done=1 and busy=0 at edge 16.
- Backpressure: as basic, but m_ready=0 for 5 cycles after the first m_valid.
  - m_data stays 0x00400 and m_valid stays 1 the whole time.
  - Exactly 2 handshakes occur in total; no element is duplicated or dropped.
- No spurious restart: src_done held high for 50 cycles after done.
  - Exactly 2 handshakes total; done stays 1.
  - Then src_done goes 0 for 1 cycle and back to 1: a second pass runs, done clears and then sets again.
- Reset mid-pass: assert reset while in WAIT for element 1.
  - All outputs 0 asynchronously.
  - Release with src_done=1: a full pass restarts from index 0.
- READ_LATENCY=3 with a BRAM model of latency 3: m_valid rises 4 edges after the start edge, and the captured data match the BRAM contents.
- LATENT_RELU_EN defined, basic stimulus: second element m_data=0x00000; the first is unchanged at 0x00400.
